// File: rtl/fcc_pkg.sv
// Shared types and constants for the frame-scan controller and fcc_top.
// Carries the point payload struct, the FSM state encoding and the ground test.
package fcc_pkg;

  localparam int unsigned W      = 16;
  localparam int unsigned ROWS   = 64;
  localparam int unsigned COLS   = 900;
  localparam int unsigned ROW_W  = 8;
  localparam int unsigned COL_W  = 10;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = 16;

  localparam logic signed [W-1:0] GROUND_Z_DEF = -16'sd1500;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [ROW_W-1:0]    row;
    logic [COL_W-1:0]    col;
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic signed [W-1:0] z;
    logic                is_ground;
  } point_t;

  // Strictly below the threshold counts as ground.
  function automatic logic is_ground_f(input logic signed [W-1:0] z,
                                       input logic signed [W-1:0] thr);
    return z < thr;
  endfunction

endpackage

// File: rtl/fcc_scan_ctrl_if.sv
// Point-memory read port plus the fcc_top input handshake and output monitor.
// The controller drives through master; memory/fcc_top side uses slave.
interface fcc_scan_ctrl_if;
  import fcc_pkg::*;

  logic                mem_rd_en;
  logic [ADDR_W-1:0]   mem_rd_addr;
  logic signed [W-1:0] mem_rd_x;
  logic signed [W-1:0] mem_rd_y;
  logic signed [W-1:0] mem_rd_z;

  logic                in_valid;
  logic                in_ready;
  logic [ROW_W-1:0]    in_row;
  logic [COL_W-1:0]    in_col;
  logic signed [W-1:0] in_x;
  logic signed [W-1:0] in_y;
  logic signed [W-1:0] in_z;
  logic                in_is_ground;

  logic                fcc_out_valid;
  logic                fcc_out_ready;

  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_x, mem_rd_y, mem_rd_z,
    output in_valid, in_row, in_col, in_x, in_y, in_z, in_is_ground,
    input  in_ready,
    input  fcc_out_valid, fcc_out_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_x, mem_rd_y, mem_rd_z,
    input  in_valid, in_row, in_col, in_x, in_y, in_z, in_is_ground,
    output in_ready,
    output fcc_out_valid, fcc_out_ready
  );

endinterface

// File: rtl/fcc_scan_addr_gen.sv
// Raster-order row/col/address walker over a window anchored at (0,0).
// The address steps incrementally so no row*COLS multiplier is needed.
module fcc_scan_addr_gen
  import fcc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  input  logic [ROW_W-1:0]  rows,
  input  logic [COL_W-1:0]  cols,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic [ADDR_W-1:0] addr,
  output logic              last_c
);

  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

  logic col_end_c;

  assign col_end_c = (col == (cols - COL_W'(1)));
  assign last_c    = col_end_c && (row == (rows - ROW_W'(1)));

  // Wrapping to the next row skips the columns outside the window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (clr) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (adv) begin
      if (col_end_c) begin
        col  <= '0;
        row  <= row + ROW_W'(1);
        addr <= addr + COLS_A - ADDR_W'(cols) + ADDR_W'(1);
      end else begin
        col  <= col + COL_W'(1);
        addr <= addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/fcc_scan_ctrl.sv
// Frame-scan controller: walks the point memory window, skips empty pixels,
// feeds non-empty points to fcc_top and waits for its results to drain.
module fcc_scan_ctrl
  import fcc_pkg::*;
#(
  parameter logic signed [W-1:0] GROUND_Z = GROUND_Z_DEF,
  parameter int unsigned         TIMEOUT  = 60000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ROW_W-1:0] cfg_rows,
  input  logic [COL_W-1:0] cfg_cols,
  input  logic [CNT_W-1:0] cfg_max_pts,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] sent_cnt,
  output logic [CNT_W-1:0] recv_cnt,
  fcc_scan_ctrl_if.master  bus
);

  localparam int unsigned     TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t           state;
  logic [ROW_W-1:0] rows_q;
  logic [COL_W-1:0] cols_q;
  logic [CNT_W-1:0] max_q;
  logic [TO_W-1:0]  tcnt;
  point_t           pt_q;
  logic             in_valid_q;
  logic             mem_rd_en_q;

  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] addr;
  logic              last_c;
  logic              clr_c;
  logic              adv_c;
  logic              hs_c;
  logic              empty_c;
  logic              cap_hit_c;
  logic [CNT_W-1:0]  sent_next_c;

  assign clr_c       = (state == S_IDLE) && start;
  assign hs_c        = in_valid_q && bus.in_ready;
  assign empty_c     = (bus.mem_rd_x == '0) && (bus.mem_rd_y == '0) && (bus.mem_rd_z == '0);
  assign adv_c       = ((state == S_LOAD) && empty_c) || ((state == S_SEND) && hs_c);
  assign sent_next_c = sent_cnt + CNT_W'(1);
  assign cap_hit_c   = (max_q != '0) && (sent_next_c == max_q);

  fcc_scan_addr_gen u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr_c),
    .adv    (adv_c),
    .rows   (rows_q),
    .cols   (cols_q),
    .row    (row),
    .col    (col),
    .addr   (addr),
    .last_c (last_c)
  );

  assign bus.mem_rd_en    = mem_rd_en_q;
  assign bus.mem_rd_addr  = addr;
  assign bus.in_valid     = in_valid_q;
  assign bus.in_row       = pt_q.row;
  assign bus.in_col       = pt_q.col;
  assign bus.in_x         = pt_q.x;
  assign bus.in_y         = pt_q.y;
  assign bus.in_z         = pt_q.z;
  assign bus.in_is_ground = pt_q.is_ground;

  // Results are counted in every active state, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      recv_cnt <= '0;
    end else if (clr_c) begin
      recv_cnt <= '0;
    end else if ((state != S_IDLE) && bus.fcc_out_valid && bus.fcc_out_ready
                 && (recv_cnt != '1)) begin
      recv_cnt <= recv_cnt + CNT_W'(1);
    end
  end

  // Scan FSM; strobes default low and are raised on entry to their state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      max_q       <= '0;
      tcnt        <= '0;
      pt_q        <= '0;
      in_valid_q  <= 1'b0;
      mem_rd_en_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      sent_cnt    <= '0;
    end else begin
      done        <= 1'b0;
      mem_rd_en_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            rows_q      <= (cfg_rows == '0) ? ROW_W'(1) : cfg_rows;
            cols_q      <= (cfg_cols == '0) ? COL_W'(1) : cfg_cols;
            max_q       <= cfg_max_pts;
            tcnt        <= '0;
            sent_cnt    <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            mem_rd_en_q <= 1'b1;
            state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          if (empty_c) begin
            if (last_c) begin
              state <= S_DRAIN;
            end else begin
              mem_rd_en_q <= 1'b1;
              state       <= S_FETCH;
            end
          end else begin
            pt_q.row       <= row;
            pt_q.col       <= col;
            pt_q.x         <= bus.mem_rd_x;
            pt_q.y         <= bus.mem_rd_y;
            pt_q.z         <= bus.mem_rd_z;
            pt_q.is_ground <= is_ground_f(bus.mem_rd_z, GROUND_Z);
            in_valid_q     <= 1'b1;
            state          <= S_SEND;
          end
        end
        S_SEND: begin
          if (hs_c) begin
            in_valid_q <= 1'b0;
            sent_cnt   <= sent_next_c;
            if (last_c || cap_hit_c) begin
              state <= S_DRAIN;
            end else begin
              mem_rd_en_q <= 1'b1;
              state       <= S_FETCH;
            end
          end
        end
        S_DRAIN: begin
          tcnt <= tcnt + TO_W'(1);
          if (recv_cnt >= sent_cnt) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (tcnt == TO_LAST) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fcc_scan_ctrl.sv
// Self-checking bench for fcc_scan_ctrl: memory model, fcc_top stub,
// point scoreboard, table of frame vectors plus hand-written corner sequences.
module tb_fcc_scan_ctrl;
  import fcc_pkg::*;

  localparam int unsigned TB_TIMEOUT = 500;

  typedef struct {
    int rows;
    int cols;
    int maxp;
    int pat;
    int exp_sent;
    int exp_lat;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [ROW_W-1:0] cfg_rows = '0;
  logic [COL_W-1:0] cfg_cols = '0;
  logic [CNT_W-1:0] cfg_max_pts = '0;
  logic             busy, done, timeout_err;
  logic [CNT_W-1:0] sent_cnt, recv_cnt;
  logic             in_rdy = 1'b1;
  logic             stub_en = 1'b1;

  fcc_scan_ctrl_if bus();

  fcc_scan_ctrl #(.GROUND_Z(GROUND_Z_DEF), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_max_pts(cfg_max_pts),
    .busy(busy), .done(done), .timeout_err(timeout_err),
    .sent_cnt(sent_cnt), .recv_cnt(recv_cnt), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [W-1:0] mx [ROWS*COLS];
  logic signed [W-1:0] my [ROWS*COLS];
  logic signed [W-1:0] mz [ROWS*COLS];

  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_rd_x <= mx[bus.mem_rd_addr];
      bus.mem_rd_y <= my[bus.mem_rd_addr];
      bus.mem_rd_z <= mz[bus.mem_rd_addr];
    end
  end

  // fcc_top stub: one result per accepted point, one cycle later at the earliest.
  int pending = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) pending <= 0;
    else pending <= pending + int'(bus.in_valid && bus.in_ready)
                            - int'(bus.fcc_out_valid && bus.fcc_out_ready);
  end
  assign bus.in_ready      = in_rdy;
  assign bus.fcc_out_valid = stub_en && (pending != 0);
  assign bus.fcc_out_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int rd_count = 0;
  int last_rd = 0;
  int hs_count = 0;
  int hs_edge = 0;
  logic [7:0] gnd_bits = '0;
  point_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] payload();
    return 64'({bus.in_valid, bus.in_row, bus.in_col, bus.in_x, bus.in_y, bus.in_z, bus.in_is_ground});
  endfunction

  // Monitor: sampled on the falling edge, i.e. the values the next rising edge uses.
  initial begin
    point_t got, want;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.mem_rd_en) begin
          rd_count++;
          last_rd = int'(bus.mem_rd_addr);
        end
        if (bus.in_valid && bus.in_ready) begin
          got = '{row: bus.in_row, col: bus.in_col, x: bus.in_x, y: bus.in_y,
                  z: bus.in_z, is_ground: bus.in_is_ground};
          hs_count++;
          hs_edge  = cyc + 1;
          gnd_bits = {gnd_bits[6:0], bus.in_is_ground};
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra actual=%0h required=none", got);
          end else begin
            want = exp_q.pop_front();
            check("sb_point", 64'(got), 64'(want));
          end
        end
      end
    end
  end

  task automatic set_pt(input int r, input int c, input int x, input int y, input int z);
    mx[r*COLS+c] = W'(x);
    my[r*COLS+c] = W'(y);
    mz[r*COLS+c] = W'(z);
  endtask

  task automatic fill_pattern(input int pat);
    foreach (mx[i]) begin
      mx[i] = '0; my[i] = '0; mz[i] = '0;
    end
    case (pat)
      1: begin set_pt(0, 1, 100, -200, 300); set_pt(1, 3, -5, 7, -2000); end
      2: begin
        for (int c = 0; c < 8; c++) set_pt(0, c, c + 1, -(c + 1), c * 3);
        set_pt(0, 1, 0, 0, 5);
        set_pt(1, 0, 50, 0, 0);
        set_pt(1, 1, 51, 0, 0);
      end
      3: begin set_pt(0, 0, 1, 1, -1501); set_pt(0, 1, 2, 2, -1500); end
      4: begin set_pt(0, 0, 9, 9, 9); set_pt(0, 1, 8, 8, 8); set_pt(1, 0, 7, 7, 7); end
      5: begin set_pt(0, 5, 3, 4, 5); set_pt(2, 899, -1, -1, -32768); set_pt(3, 0, 1, 1, 1); end
      6: set_pt(0, 0, 11, 22, 33);
      7: begin set_pt(0, 0, 4, 5, 6); set_pt(0, 1, 7, 8, 9); end
      default: ;
    endcase
  endtask

  // Reference raster walk: queues the points expected on in_*, plus read stats.
  task automatic model_scan(input int rows, input int cols, input int maxp,
                            output int reads, output int last);
    int re, ce, n, a;
    bit stop;
    re = (rows == 0) ? 1 : rows;
    ce = (cols == 0) ? 1 : cols;
    n = 0; reads = 0; last = 0; stop = 0;
    for (int r = 0; r < re; r++) begin
      for (int c = 0; c < ce; c++) begin
        if (!stop) begin
          a = r * COLS + c;
          reads++;
          last = a;
          if (mx[a] != 0 || my[a] != 0 || mz[a] != 0) begin
            exp_q.push_back('{row: ROW_W'(r), col: COL_W'(c), x: mx[a], y: my[a],
                              z: mz[a], is_ground: (mz[a] < GROUND_Z_DEF)});
            n++;
            if (maxp != 0 && n == maxp) stop = 1;
          end
        end
      end
    end
  endtask

  task automatic wait_done(input int budget, output int done_edge);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (done) ok = 1;
      else tick();
    end
    done_edge = cyc;
    check("done_seen", 64'(ok), 64'd1);
    if (ok) begin
      tick();
      check("done_pulse_busy", 64'({done, busy}), 64'd0);
    end
  endtask

  task automatic run_frame(input int rows, input int cols, input int maxp,
                           output int lat, output int done_edge);
    int s_edge;
    cfg_rows    = ROW_W'(rows);
    cfg_cols    = COL_W'(cols);
    cfg_max_pts = CNT_W'(maxp);
    start  = 1'b1;
    s_edge = cyc + 1;
    tick();
    start = 1'b0;
    wait_done(20000, done_edge);
    lat = done_edge - s_edge;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    exp_q.delete();
  endtask

  vec_t vecs[6];

  initial begin
    int reads, last, lat, dedge, hs0;
    logic [63:0] snap;

    vecs[0] = '{rows: 5, cols: 60,  maxp: 0, pat: 0, exp_sent: 0, exp_lat: 601};
    vecs[1] = '{rows: 2, cols: 4,   maxp: 0, pat: 1, exp_sent: 2, exp_lat: -1};
    vecs[2] = '{rows: 2, cols: 8,   maxp: 3, pat: 2, exp_sent: 3, exp_lat: -1};
    vecs[3] = '{rows: 1, cols: 2,   maxp: 0, pat: 3, exp_sent: 2, exp_lat: -1};
    vecs[4] = '{rows: 0, cols: 0,   maxp: 0, pat: 4, exp_sent: 1, exp_lat: -1};
    vecs[5] = '{rows: 3, cols: 900, maxp: 0, pat: 5, exp_sent: 2, exp_lat: -1};

    tick(); tick();
    check("reset_outs", 64'({busy, done, timeout_err, sent_cnt, recv_cnt,
                             bus.mem_rd_en, bus.mem_rd_addr, bus.in_valid}), 64'd0);
    rst = 1'b1;
    tick();
    check("idle_outs", 64'({busy, done, timeout_err, bus.mem_rd_en, bus.in_valid}), 64'd0);

    foreach (vecs[i]) begin
      fill_pattern(vecs[i].pat);
      model_scan(vecs[i].rows, vecs[i].cols, vecs[i].maxp, reads, last);
      rd_count = 0;
      gnd_bits = '0;
      run_frame(vecs[i].rows, vecs[i].cols, vecs[i].maxp, lat, dedge);
      check("v_sent", 64'(sent_cnt), 64'(vecs[i].exp_sent));
      check("v_recv", 64'(recv_cnt), 64'(vecs[i].exp_sent));
      check("v_timeout", 64'(timeout_err), 64'd0);
      check("v_reads", 64'(rd_count), 64'(reads));
      check("v_last_addr", 64'(last_rd), 64'(last));
      check("v_sb_empty", 64'(exp_q.size()), 64'd0);
      if (vecs[i].exp_lat >= 0) check("v_latency", 64'(lat), 64'(vecs[i].exp_lat));
      if (vecs[i].pat == 1) check("v_addr_1_3", 64'(last_rd), 64'd903);
      if (vecs[i].pat == 3) check("v_ground", 64'(gnd_bits[1:0]), 64'b10);
      if (exp_q.size() != 0) do_reset();
    end

    // Back-pressure: payload must hold while in_ready is low; a second start is ignored.
    fill_pattern(6);
    model_scan(1, 1, 0, reads, last);
    rd_count = 0;
    hs0 = hs_count;
    in_rdy = 1'b0;
    cfg_rows = 8'd1; cfg_cols = COL_W'(1); cfg_max_pts = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && !bus.in_valid; i++) tick();
    check("stall_valid", 64'(bus.in_valid), 64'd1);
    snap = payload();
    cfg_rows = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("stall_hold", payload(), snap);
      tick();
    end
    in_rdy = 1'b1;
    wait_done(200, dedge);
    check("stall_one_hs", 64'(hs_count - hs0), 64'd1);
    check("stall_sent", 64'(sent_cnt), 64'd1);
    check("stall_reads", 64'(rd_count), 64'd1);

    // Drain timeout: fcc_top never answers.
    stub_en = 1'b0;
    fill_pattern(6);
    model_scan(1, 1, 0, reads, last);
    run_frame(1, 1, 0, lat, dedge);
    check("to_latency", 64'(dedge - hs_edge), 64'(TB_TIMEOUT));
    check("to_flags", 64'({timeout_err, recv_cnt, sent_cnt}), 64'({1'b1, 16'd0, 16'd1}));
    tick();
    check("to_sticky", 64'(timeout_err), 64'd1);
    stub_en = 1'b1;
    tick(); tick(); tick();

    // Asynchronous reset while a point is being offered, then a clean rescan.
    fill_pattern(7);
    in_rdy = 1'b0;
    cfg_rows = 8'd1; cfg_cols = COL_W'(2); cfg_max_pts = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("to_cleared", 64'(timeout_err), 64'd0);
    for (int i = 0; i < 20 && !bus.in_valid; i++) tick();
    check("rst_pre_valid", 64'(bus.in_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async", 64'({bus.in_valid, busy}), 64'd0);
    exp_q.delete();
    tick();
    rst = 1'b1;
    in_rdy = 1'b1;
    tick();
    model_scan(1, 2, 0, reads, last);
    rd_count = 0;
    run_frame(1, 2, 0, lat, dedge);
    check("rst_resent", 64'(sent_cnt), 64'd2);
    check("rst_reads", 64'(rd_count), 64'(reads));
    check("rst_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fcc_scan_ctrl.md
Name: fcc_scan_ctrl

Overview:
- Frame-scan controller in front of fcc_top.
- Walks a configurable row/column window of the range-image point memory in raster order and skips empty pixels (x=y=z=0).
- Presents each non-empty point to fcc_top on its in_* valid/ready interface, with a ground flag from a z threshold.
- Counts fcc_top results, then reports done or timeout. Replaces bench-side ad-hoc stimulus loops.

Parameters:
- W, 16, coordinate width (signed).
- ROWS, 64, range-image rows.
- COLS, 900, range-image columns.
- COL_W, 10, column index width.
- ADDR_W, 16, point-memory address width (must hold ROWS*COLS-1).
- CNT_W, 16, point counter width.
- GROUND_Z, -16'sd1500, signed z threshold; z < GROUND_Z means ground.
- TIMEOUT, 60000, drain-timeout cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame start pulse; ignored unless IDLE.
- cfg_rows  in  8  window rows, starting at row 0; range 1..ROWS.
- cfg_cols  in  COL_W  window columns, starting at col 0; range 1..COLS.
- cfg_max_pts  in  CNT_W  point send cap; 0 means unlimited.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at frame end.
- timeout_err  out  1  sticky until next start.
- sent_cnt  out  CNT_W  points handed to fcc_top.
- recv_cnt  out  CNT_W  fcc_top results observed.
- mem_rd_en  out  1  point-memory read strobe.
- mem_rd_addr  out  ADDR_W  address = row*COLS+col.
- mem_rd_x, mem_rd_y, mem_rd_z  in  W each  read data, valid exactly 1 cycle after mem_rd_en.
- in_valid  out  1  to fcc_top.
- in_ready  in  1  from fcc_top.
- in_row  out  8  to fcc_top.
- in_col  out  COL_W  to fcc_top.
- in_x, in_y, in_z  out  W each  to fcc_top.
- in_is_ground  out  1  to fcc_top.
- fcc_out_valid, fcc_out_ready  in  1 each  fcc_top output handshake, monitored only.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE; all outputs 0.
  - row, col, addr, sent_cnt, recv_cnt, timeout counter all 0.
  - Reset mid-frame drops in_valid immediately; fcc_top shares the same reset.
- States: IDLE, FETCH, LOAD, SEND, DRAIN, DONE.
- IDLE:
  - start=1: latch cfg_*, clear counters and timeout_err, row=col=addr=0, busy=1, go to FETCH.
- FETCH: mem_rd_en=1, mem_rd_addr=addr, go to LOAD.
- LOAD: data is valid.
  - x=y=z=0: advance position, then go to FETCH (or DRAIN if last pixel).
  - Otherwise: register row, col, x, y, z and is_ground=($signed(z) < GROUND_Z), go to SEND.
- SEND:
  - in_valid=1; payload held stable until in_valid&&in_ready.
  - On handshake: sent_cnt+1, in_valid=0 next cycle, advance position.
  - Then go to DRAIN if last pixel or (cfg_max_pts!=0 and new sent_cnt==cfg_max_pts), else FETCH.
- Advance position:
  - col+1 and addr+1.
  - At col==cfg_cols-1: col=0, row+1, addr += COLS-cfg_cols+1. No multiplier.
  - Last pixel: row==cfg_rows-1 and col==cfg_cols-1.
- Throughput: empty pixel 2 cycles; non-empty pixel at least 3 cycles.
- recv_cnt:
  - Increments on every cycle with fcc_out_valid&&fcc_out_ready, in any state except IDLE.
  - Saturates at all-ones.
- DRAIN:
  - Timeout counter increments each cycle.
  - recv_cnt >= sent_cnt: go to DONE.
  - Otherwise counter == TIMEOUT-1: set timeout_err=1, go to DONE.
  - Simultaneous match and timeout: match wins, timeout_err stays 0.
- DONE: done=1 for one cycle, busy=0 next cycle, go to IDLE. Counters hold their values until the next start.
- Error cases:
  - cfg_rows=0 or cfg_cols=0: treated as 1.
  - start while busy: ignored.

Decomposition:
- Package fcc_pkg holds:
  - state enum;
  - W, COL_W, ROWS, COLS, CNT_W;
  - the default GROUND_Z constant;
  - a point struct {row, col, x, y, z, is_ground} shared with fcc_top.
- One sub-module fcc_scan_addr_gen: row/col/addr counters, advance and last-pixel logic.

Test Plan:
- Window 5x60, memory all zero.
  - Required: no in_valid; DRAIN immediate; done pulses; sent_cnt=0.
  - Required: done at cycle 2*300 + small constant after start.
- Window 2x4, non-zero points at (0,1) and (1,3).
  - Required: in_row/in_col = (0,1) then (1,3).
  - Required: mem_rd_addr for (1,3) = 903.
  - Required: stub returns 2 results; sent_cnt=recv_cnt=2; timeout_err=0.
- in_ready held low 10 cycles during SEND.
  - Required: payload stable throughout; exactly one handshake counted.
- cfg_max_pts=3 with 10 non-zero points.
  - Required: only the first 3 raster-order points sent, then DRAIN.
- Stub fcc_top never asserts fcc_out_valid.
  - Required: timeout_err=1 and done exactly TIMEOUT cycles after DRAIN entry.
- Ground flag: z=-1501 -> in_is_ground=1; z=-1500 -> 0.
- rst low mid-SEND: in_valid=0 without waiting for a clock edge; a new start after release rescans from (0,0).
